counter_mod_updown: RTL

- Parametrised successor to the team's 4-bit loadable counter.
- Provides an N-bit up/down counter with a programmable modulus, a count enable, a synchronous load, and a selectable wrap or saturate mode.
- Generates a combinational terminal-count flag and a registered one-cycle wrap pulse.
- Used as a timebase/event counter wherever fixed 4-bit counters were instantiated.

---
 rtl/counter_mod_updown.sv | 73 +++++++
 1 files changed

// File: rtl/counter_mod_updown.sv
// N-bit up/down counter with programmable modulus, load and wrap/saturate.
// Terminal count is combinational; the wrap pulse is registered.
module counter_mod_updown #(
  parameter int                WIDTH    = 4,
  parameter longint unsigned   MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
  parameter bit                SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MOD_MAX);
  localparam logic [WIDTH:0]   MAXX = {1'b0, MAXW};

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_ld;

  // Widened arithmetic: carry/borrow land in the extra bit
  assign w_inc     = {1'b0, r_count} + 1'b1;
  assign w_dec     = {1'b0, r_count} - 1'b1;
  assign w_at_max  = (w_inc > MAXX);
  assign w_at_zero = w_dec[WIDTH];

  assign w_ld = ({1'b0, load_data} > MAXX) ? MAXW : load_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_ld;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_wrap <= 1'b0;
      if (up_dn) begin
        if (!w_at_max) begin
          r_count <= w_inc[WIDTH-1:0];
        end else if (!SATURATE) begin
          r_count <= '0;
          r_wrap  <= 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          r_count <= w_dec[WIDTH-1:0];
        end else if (!SATURATE) begin
          r_count <= MAXW;
          r_wrap  <= 1'b1;
        end
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = en & ~load &
                 ((up_dn & w_at_max) | (~up_dn & w_at_zero));

endmodule
